demultiplexer4_stream: RTL and testbench



---
 rtl/demux_pkg.sv | 9 +
 rtl/demultiplexer4_stream_if.sv | 28 ++
 rtl/demux_slot.sv | 82 ++++++++
 rtl/demultiplexer4_stream.sv | 43 ++++
 tb/tb_demultiplexer4_stream.sv | 236 +++++++++++++++++++++++
 5 files changed

// File: rtl/demux_pkg.sv
// rtl/demux_pkg.sv - shared constants and types for the 1-to-4 stream demultiplexer
package demux_pkg;

    localparam int CHANNELS = 4;

    typedef logic [1:0] chan_sel_t;
    typedef logic [1:0] slot_count_t;

endpackage

// File: rtl/demultiplexer4_stream_if.sv
// rtl/demultiplexer4_stream_if.sv - input stream, four output channels and their handshakes
interface demultiplexer4_stream_if #(
    parameter int WIDTH = 32
);
    import demux_pkg::*;

    logic                in_valid;
    logic                in_ready;
    logic [WIDTH-1:0]    in_data;
    chan_sel_t           in_sel;
    logic [CHANNELS-1:0] out_valid;
    logic [CHANNELS-1:0] out_ready;
    logic [WIDTH-1:0]    out_data0;
    logic [WIDTH-1:0]    out_data1;
    logic [WIDTH-1:0]    out_data2;
    logic [WIDTH-1:0]    out_data3;

    modport slave (
        input  in_valid, in_data, in_sel, out_ready,
        output in_ready, out_valid, out_data0, out_data1, out_data2, out_data3
    );

    modport master (
        output in_valid, in_data, in_sel, out_ready,
        input  in_ready, out_valid, out_data0, out_data1, out_data2, out_data3
    );

endinterface

// File: rtl/demux_slot.sv
// rtl/demux_slot.sv - one channel's storage; two-entry skid slot when DEMUX4_STREAM_SKID_EN is defined
module demux_slot
    import demux_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop_ready,
    output logic             pop_valid,
    output logic [WIDTH-1:0] pop_data,
    output logic             can_push
);

    logic pop;
    assign pop = pop_valid && pop_ready;

`ifdef DEMUX4_STREAM_SKID_EN
    slot_count_t      count;
    logic [WIDTH-1:0] head;
    logic [WIDTH-1:0] tail;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
            head  <= '0;
            tail  <= '0;
        end else begin
            case ({push, pop})
                2'b10: begin
                    if (count == 2'd0) head <= push_data;
                    else               tail <= push_data;
                    count <= count + 2'd1;
                end
                2'b01: begin
                    head  <= tail;
                    count <= count - 2'd1;
                end
                2'b11: begin
                    // occupancy stays put; the head is replaced by whichever word is next in line
                    if (count == 2'd1) begin
                        head <= push_data;
                    end else begin
                        head <= tail;
                        tail <= push_data;
                    end
                end
                default: ;
            endcase
        end
    end

    assign pop_valid = (count != 2'd0);
    assign pop_data  = head;
    assign can_push  = (count != 2'd2);
`else
    logic             full;
    logic [WIDTH-1:0] head;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            full <= 1'b0;
            head <= '0;
        end else begin
            if (push) begin
                head <= push_data;
                full <= 1'b1;
            end else if (pop) begin
                full <= 1'b0;
            end
        end
    end

    assign pop_valid = full;
    assign pop_data  = head;
    // a full slot can still take a word in the same cycle its consumer drains it
    assign can_push  = !full || pop_ready;
`endif

endmodule

// File: rtl/demultiplexer4_stream.sv
// rtl/demultiplexer4_stream.sv - registered 1-to-4 stream demux; DEMUX4_STREAM_SKID_EN selects two-deep slots
module demultiplexer4_stream
    import demux_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic                    clock,
    input  logic                    reset_n,
    demultiplexer4_stream_if.slave  bus
);

    logic [CHANNELS-1:0] push;
    logic [CHANNELS-1:0] slot_ready;
    logic [CHANNELS-1:0] slot_valid;
    logic [WIDTH-1:0]    slot_data [CHANNELS];

    // held low during reset so nothing is accepted while the slots are being cleared
    assign bus.in_ready = reset_n && slot_ready[bus.in_sel];

    for (genvar i = 0; i < CHANNELS; i++) begin : g_slot
        assign push[i] = bus.in_valid && bus.in_ready && (bus.in_sel == chan_sel_t'(i));

        demux_slot #(
            .WIDTH (WIDTH)
        ) u_slot (
            .clock     (clock),
            .reset_n   (reset_n),
            .push      (push[i]),
            .push_data (bus.in_data),
            .pop_ready (bus.out_ready[i]),
            .pop_valid (slot_valid[i]),
            .pop_data  (slot_data[i]),
            .can_push  (slot_ready[i])
        );
    end

    assign bus.out_valid = slot_valid;
    assign bus.out_data0 = slot_data[0];
    assign bus.out_data1 = slot_data[1];
    assign bus.out_data2 = slot_data[2];
    assign bus.out_data3 = slot_data[3];

endmodule

// File: tb/tb_demultiplexer4_stream.sv
// tb/tb_demultiplexer4_stream.sv - directed vector bench for demultiplexer4_stream
module tb_demultiplexer4_stream;

`ifdef DEMUX4_STREAM_SKID_EN
    localparam int DEPTH = 2;
`else
    localparam int DEPTH = 1;
`endif

    logic clock = 1'b0;
    logic reset_n;
    int   n_cmp = 0;
    int   n_bad = 0;

    always #5 clock = ~clock;

    demultiplexer4_stream_if #(.WIDTH(32)) bus ();

    demultiplexer4_stream #(.WIDTH(32)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    typedef struct {
        logic        v;
        logic [1:0]  sel;
        logic [31:0] data;
        logic [3:0]  ordy;
        logic        exp_ir;
        logic [3:0]  exp_ov;
        logic [31:0] exp_d;
    } vec_t;

    vec_t        tbl [14];
    logic [31:0] expq [4][$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] odata(input int ch);
        case (ch)
            0:       return bus.out_data0;
            1:       return bus.out_data1;
            2:       return bus.out_data2;
            default: return bus.out_data3;
        endcase
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // protocol monitor: held inputs and held outputs must not move until their transfer
    logic        in_pend = 1'b0;
    logic [1:0]  in_psel;
    logic [31:0] in_pdata;
    logic [3:0]  o_pend = 4'b0;
    logic [31:0] o_pdata [4];

    always @(negedge clock) begin
        if (!reset_n) begin
            in_pend = 1'b0;
            o_pend  = 4'b0;
        end else begin
            if (in_pend && bus.in_valid) begin
                chk("in_stable", {bus.in_sel, bus.in_data[29:0]}, {in_psel, in_pdata[29:0]});
            end
            in_pend  = bus.in_valid && !bus.in_ready;
            in_psel  = bus.in_sel;
            in_pdata = bus.in_data;
            for (int c = 0; c < 4; c++) begin
                if (o_pend[c]) begin
                    chk("out_hold_v", 32'(bus.out_valid[c]), 32'd1);
                    chk("out_hold_d", odata(c), o_pdata[c]);
                end
                o_pend[c]  = bus.out_valid[c] && !bus.out_ready[c];
                o_pdata[c] = odata(c);
            end
        end
    end

    initial begin
        int sent;
        int got;

        tbl[0] = '{1'b1, 2'd2, 32'hA5A5_0001, 4'hF, 1'b1, 4'b0100, 32'hA5A5_0001};
        for (int k = 0; k < 8; k++)
            tbl[1+k] = '{1'b1, 2'd1, 32'h10 + k, 4'hF, 1'b1, 4'b0010, 32'h10 + k};
        for (int k = 0; k < 4; k++)
            tbl[9+k] = '{1'b1, 2'(k), 32'hC0 + k, 4'hF, 1'b1, 4'(1 << k), 32'hC0 + k};
        tbl[13] = '{1'b0, 2'd0, 32'h0, 4'hF, 1'b1, 4'b0000, 32'h0};

        reset_n       = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_sel    = 2'd0;
        bus.in_data   = '0;
        bus.out_ready = 4'hF;
        #2;
        chk("rst_ov", 32'(bus.out_valid), 32'h0);
        chk("rst_ir", 32'(bus.in_ready), 32'h0);
        repeat (2) @(posedge clock);
        #1 reset_n = 1'b1;
        #1;
        chk("rel_ir", 32'(bus.in_ready), 32'h1);
        chk("rel_ov", 32'(bus.out_valid), 32'h0);

        for (int i = 0; i < 14; i++) begin
            bus.in_valid  = tbl[i].v;
            bus.in_sel    = tbl[i].sel;
            bus.in_data   = tbl[i].data;
            bus.out_ready = tbl[i].ordy;
            #1;
            chk($sformatf("vec%0d_ir", i), 32'(bus.in_ready), 32'(tbl[i].exp_ir));
            tick();
            chk($sformatf("vec%0d_ov", i), 32'(bus.out_valid), 32'(tbl[i].exp_ov));
            if (tbl[i].exp_ov[tbl[i].sel])
                chk($sformatf("vec%0d_d", i), odata(int'(tbl[i].sel)), tbl[i].exp_d);
        end

        // back-pressure on channel 3 fills its slot but leaves channel 0 open
        bus.out_ready = 4'b0111;
        bus.in_valid  = 1'b1;
        bus.in_sel    = 2'd3;
        bus.in_data   = 32'h30;
        #1 chk("bp_acc0", 32'(bus.in_ready), 32'h1);
        tick();
        for (int k = 1; k < 3; k++) begin
            bus.in_data = 32'h30 + k;
            #1 chk($sformatf("bp_acc%0d", k), 32'(bus.in_ready), 32'(k < DEPTH));
            if (k >= DEPTH) break;
            tick();
        end
        bus.in_valid = 1'b0;
        bus.in_sel   = 2'd3;
        #1 chk("bp_ir3", 32'(bus.in_ready), 32'h0);
        bus.in_sel = 2'd0;
        #1 chk("bp_ir0", 32'(bus.in_ready), 32'h1);
        bus.in_valid = 1'b1;
        bus.in_data  = 32'h40;
        tick();
        bus.in_valid = 1'b0;
        chk("bp_ov", 32'(bus.out_valid), 32'b1001);
        chk("bp_d3", bus.out_data3, 32'h30);
        chk("bp_d0", bus.out_data0, 32'h40);
        bus.out_ready = 4'hF;
        tick();
        chk("drain_v", 32'(bus.out_valid[3]), 32'(DEPTH == 2));
        for (int k = 1; k < DEPTH; k++) begin
            chk("drain_d", bus.out_data3, 32'h30 + k);
            tick();
        end
        chk("drain_empty", 32'(bus.out_valid), 32'h0);

        // push and pop together on an occupied channel 0
        bus.out_ready = 4'b1110;
        bus.in_valid  = 1'b1;
        bus.in_sel    = 2'd0;
        bus.in_data   = 32'hAA;
        tick();
        bus.in_valid = 1'b0;
        chk("pp_held", bus.out_data0, 32'hAA);
        bus.out_ready = 4'hF;
        bus.in_valid  = 1'b1;
        bus.in_data   = 32'hBEEF;
        #1 chk("pp_ir", 32'(bus.in_ready), 32'h1);
        tick();
        bus.in_valid = 1'b0;
        chk("pp_ov", 32'(bus.out_valid), 32'b0001);
        chk("pp_d", bus.out_data0, 32'hBEEF);
        tick();
        chk("pp_empty", 32'(bus.out_valid), 32'h0);

        // round robin with random consumers against a per-channel scoreboard
        sent = 0;
        got  = 0;
        for (int cyc = 0; cyc < 300 && got < 16; cyc++) begin
            bus.in_valid  = (sent < 16);
            bus.in_sel    = 2'(sent % 4);
            bus.in_data   = 32'hC0 + sent;
            bus.out_ready = 4'($urandom);
            #1;
            for (int c = 0; c < 4; c++) begin
                if (bus.out_valid[c] && bus.out_ready[c]) begin
                    got++;
                    if (expq[c].size() == 0) chk("rr_extra", odata(c), 32'hFFFF_FFFF);
                    else                     chk($sformatf("rr_ch%0d", c), odata(c), expq[c].pop_front());
                end
            end
            if (bus.in_valid && bus.in_ready) begin
                expq[bus.in_sel].push_back(bus.in_data);
                sent++;
            end
            tick();
        end
        bus.in_valid = 1'b0;
        chk("rr_got", 32'(got), 32'd16);
        for (int c = 0; c < 4; c++) chk("rr_left", 32'(expq[c].size()), 32'd0);

        // asynchronous reset while channels 0 and 2 hold words
        bus.out_ready = 4'b0;
        bus.in_valid  = 1'b1;
        bus.in_sel    = 2'd0;
        bus.in_data   = 32'hD0;
        tick();
        bus.in_sel  = 2'd2;
        bus.in_data = 32'hD2;
        tick();
        bus.in_valid = 1'b0;
        chk("ar_pre", 32'(bus.out_valid), 32'b0101);
        #2 reset_n = 1'b0;
        #1;
        chk("ar_ov", 32'(bus.out_valid), 32'h0);
        for (int c = 0; c < 4; c++) chk($sformatf("ar_d%0d", c), odata(c), 32'h0);
        chk("ar_ir", 32'(bus.in_ready), 32'h0);
        @(posedge clock);
        #1 reset_n = 1'b1;
        bus.out_ready = 4'hF;
        bus.in_sel    = 2'd0;
        #1 chk("ar_ir0", 32'(bus.in_ready), 32'h1);
        bus.in_sel = 2'd2;
        #1 chk("ar_ir2", 32'(bus.in_ready), 32'h1);
        tick();
        chk("ar_empty", 32'(bus.out_valid), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
